// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI initiator, its clock divider and the bench.
//   spiState_e  : FSM state encoding (IDLE=0 .. FINISH=5)
//   SPI_WIDTH   : default bits per frame
//   SPI_CLK_DIV : default clk cycles per sclk half-period
//   ctrWidth()  : counter width for a count of n, never below 1 bit
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HELD    = 3'd1,
        SETUP   = 3'd2,
        SCLK_HI = 3'd3,
        SCLK_LO = 3'd4,
        FINISH  = 3'd5
    } spiState_e;

    localparam int unsigned SPI_WIDTH   = 8;
    localparam int unsigned SPI_CLK_DIV = 4;

    // $clog2(1) is 0; a zero-width counter is not legal, so clamp to 1 bit.
    function automatic int unsigned ctrWidth(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// Phase timer for the SPI initiator.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   restart  : hold the count at zero (used while no timed phase is active)
//   phaseEnd : high on the last of every CLK_DIV cycles of a phase
module spi_clk_divider
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phaseEnd
);

    localparam int unsigned    DW   = ctrWidth(CLK_DIV);
    localparam logic [DW-1:0]  LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] count;

    assign phaseEnd = (count == LAST);

    // Wrapping on phaseEnd lets back-to-back phases start at zero without
    // the FSM having to pulse restart on every transition.
    always_ff @(posedge clk) begin
        if (reset || restart || phaseEnd) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first.
//   clk, reset : system clock, synchronous active-high reset
//   start      : request a frame (accepted in IDLE or HELD only)
//   txData     : frame to send, captured with start
//   holdCs     : captured with start; keep cs_n low after the frame
//   rxData     : word shifted in from miso, valid from the done cycle
//   busy       : frame in progress
//   done       : one-cycle end-of-frame pulse
//   cs_n, sclk, mosi : serial outputs; miso : serial input (synchronous)
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned width   = SPI_WIDTH,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] txData,
    input  logic             holdCs,
    output logic [width-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             cs_n,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int unsigned   CW       = $clog2(width + 1);
    localparam logic [CW-1:0] BITS_END = CW'(width);

    spiState_e        state, stateNext;
    logic [width-1:0] txSh, txNext;
    logic [width-1:0] rxSh, rxNext;
    logic [CW-1:0]    bitCnt, cntNext;
    logic             holdQ, holdNext;
    logic             csNext, sclkNext, mosiNext, busyNext, doneNext;
    logic [width-1:0] rxDataNext;
    logic             restart, phaseEnd;

    assign restart = (state == IDLE) || (state == HELD) || (state == FINISH);

    spi_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .phaseEnd (phaseEnd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            txSh   <= '0;
            rxSh   <= '0;
            bitCnt <= '0;
            holdQ  <= 1'b0;
            cs_n   <= 1'b1;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rxData <= '0;
        end else begin
            state  <= stateNext;
            txSh   <= txNext;
            rxSh   <= rxNext;
            bitCnt <= cntNext;
            holdQ  <= holdNext;
            cs_n   <= csNext;
            sclk   <= sclkNext;
            mosi   <= mosiNext;
            busy   <= busyNext;
            done   <= doneNext;
            rxData <= rxDataNext;
        end
    end

    always_comb begin
        stateNext  = state;
        txNext     = txSh;
        rxNext     = rxSh;
        cntNext    = bitCnt;
        holdNext   = holdQ;
        csNext     = cs_n;
        sclkNext   = sclk;
        mosiNext   = mosi;
        busyNext   = busy;
        doneNext   = 1'b0;
        rxDataNext = rxData;

        unique case (state)
            IDLE, HELD: begin
                if (start) begin
                    txNext    = txData;
                    holdNext  = holdCs;
                    cntNext   = '0;
                    csNext    = 1'b0;
                    mosiNext  = txData[width-1];
                    busyNext  = 1'b1;
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                if (phaseEnd) begin
                    sclkNext  = 1'b1;
                    stateNext = SCLK_HI;
                end
            end
            SCLK_HI: begin
                if (phaseEnd) begin
                    rxNext    = {rxSh[width-2:0], miso};
                    sclkNext  = 1'b0;
                    txNext    = txSh << 1;
                    // New MSB after the shift; zeros fill in, so mosi ends at 0.
                    mosiNext  = txSh[width-2];
                    cntNext   = bitCnt + 1'b1;
                    stateNext = SCLK_LO;
                end
            end
            SCLK_LO: begin
                if (phaseEnd) begin
                    if (bitCnt < BITS_END) begin
                        sclkNext  = 1'b1;
                        stateNext = SCLK_HI;
                    end else begin
                        // Frame-end outputs are registered on entry to FINISH so
                        // that done, rxData, busy=0 and the cs_n release are all
                        // visible during the FINISH cycle itself.
                        rxDataNext = rxSh;
                        doneNext   = 1'b1;
                        busyNext   = 1'b0;
                        cntNext    = '0;
                        csNext     = ~holdQ;
                        stateNext  = FINISH;
                    end
                end
            end
            FINISH: begin
                stateNext = holdQ ? HELD : IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
